// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: sequences a single-ported 32x32 register file.
// Three requesters share the port: clear (highest priority), writeback and
// operand read. Writeback and read alternate round-robin on a tie.
// Only one operation is in flight at a time, so a write granted before a
// read to the same index is always visible to that read.
// Optional feature macro: X0_ZERO_EN (register 0 hard-wired to zero).
module regfile_access_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  // clear requester
  input  logic          clr_req_i,
  output logic          clr_ack_o,
  // writeback requester
  input  logic          wb_req_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic [DW-1:0] wb_data_i,
  output logic          wb_ack_o,
  // operand read requester
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_rs1_i,
  input  logic [AW-1:0] rd_rs2_i,
  output logic          rd_ack_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data1_o,
  output logic [DW-1:0] rd_data2_o,
  // status
  output logic          busy_o,
  // register file pins
  output logic          rf_enable_o,
  output logic          rf_rw_o,
  output logic          rf_reset_o,
  output logic [AW-1:0] rf_rs1_o,
  output logic [AW-1:0] rf_rs2_o,
  output logic [AW-1:0] rf_rd_o,
  output logic [DW-1:0] rf_din_o,
  input  logic [DW-1:0] rf_out1_i,
  input  logic [DW-1:0] rf_out2_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    RSP  = 3'd4
  } state_e;

  state_e        state_q;
  logic          rr_last_q;   // last granted of wb/rd: 0 = wb, 1 = rd
  logic          clr_ack_q;
  logic          wb_ack_q;
  logic          rd_ack_q;
  logic          rd_valid_q;
  logic          busy_q;
  logic          rf_enable_q;
  logic          rf_rw_q;
  logic          rf_reset_q;
  logic [AW-1:0] rf_rs1_q;
  logic [AW-1:0] rf_rs2_q;
  logic [AW-1:0] rf_rd_q;
  logic [DW-1:0] rf_din_q;

  logic          grant_clr_d;
  logic          grant_wb_d;
  logic          grant_rd_d;
  logic          wr_en_d;

  // Writes to index 0 are acknowledged but never reach the array when x0 is hard-wired.
`ifdef X0_ZERO_EN
  assign wr_en_d = (wb_rd_i != '0);
`else
  assign wr_en_d = 1'b1;
`endif

  // IDLE arbitration: clear first, then round-robin between writeback and read.
  always_comb begin
    grant_clr_d = 1'b0;
    grant_wb_d  = 1'b0;
    grant_rd_d  = 1'b0;
    if (state_q == IDLE) begin
      if (clr_req_i) begin
        grant_clr_d = 1'b1;
      end else if (wb_req_i && rd_req_i) begin
        // tie goes to whichever requester was not served last
        if (rr_last_q) grant_wb_d = 1'b1;
        else           grant_rd_d = 1'b1;
      end else if (wb_req_i) begin
        grant_wb_d = 1'b1;
      end else if (rd_req_i) begin
        grant_rd_d = 1'b1;
      end
    end
  end

  // Controller FSM; every output is registered so the pins are glitch-free.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b0;
      clr_ack_q   <= 1'b0;
      wb_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      rf_enable_q <= 1'b0;
      rf_rw_q     <= 1'b0;
      rf_reset_q  <= 1'b0;
      rf_rs1_q    <= '0;
      rf_rs2_q    <= '0;
      rf_rd_q     <= '0;
      rf_din_q    <= '0;
    end else begin
      // acks and valid are single-cycle pulses unless re-asserted below
      clr_ack_q  <= 1'b0;
      wb_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_clr_d) begin
            state_q     <= CLR;
            clr_ack_q   <= 1'b1;
            busy_q      <= 1'b1;
            rf_enable_q <= 1'b1;
            rf_reset_q  <= 1'b1;
          end else if (grant_wb_d) begin
            state_q     <= WR;
            wb_ack_q    <= 1'b1;
            busy_q      <= 1'b1;
            rr_last_q   <= 1'b0;
            rf_enable_q <= wr_en_d;
            rf_rw_q     <= 1'b1;
            rf_rd_q     <= wb_rd_i;
            rf_din_q    <= wb_data_i;
          end else if (grant_rd_d) begin
            state_q     <= RD;
            rd_ack_q    <= 1'b1;
            busy_q      <= 1'b1;
            rr_last_q   <= 1'b1;
            rf_enable_q <= 1'b1;
            rf_rw_q     <= 1'b0;
            rf_rs1_q    <= rd_rs1_i;
            rf_rs2_q    <= rd_rs2_i;
          end
        end
        CLR, WR: begin
          // the register file acted on this edge; release the port
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rf_enable_q <= 1'b0;
          rf_rw_q     <= 1'b0;
          rf_reset_q  <= 1'b0;
        end
        RD: begin
          // register file captures out1/out2 on this edge; present them next cycle
          state_q     <= RSP;
          rf_enable_q <= 1'b0;
          rd_valid_q  <= 1'b1;
        end
        RSP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rf_enable_q <= 1'b0;
          rf_rw_q     <= 1'b0;
          rf_reset_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read operands pass straight through from the register file's own output registers.
`ifdef X0_ZERO_EN
  assign rd_data1_o = (rf_rs1_q == '0) ? '0 : rf_out1_i;
  assign rd_data2_o = (rf_rs2_q == '0) ? '0 : rf_out2_i;
`else
  assign rd_data1_o = rf_out1_i;
  assign rd_data2_o = rf_out2_i;
`endif

  assign clr_ack_o   = clr_ack_q;
  assign wb_ack_o    = wb_ack_q;
  assign rd_ack_o    = rd_ack_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;
  assign rf_enable_o = rf_enable_q;
  assign rf_rw_o     = rf_rw_q;
  assign rf_reset_o  = rf_reset_q;
  assign rf_rs1_o    = rf_rs1_q;
  assign rf_rs2_o    = rf_rs2_q;
  assign rf_rd_o     = rf_rd_q;
  assign rf_din_o    = rf_din_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl with a behavioural register file attached.
// Expected grants and read results are queued as stimulus is issued and
// compared by a monitor when the controller acknowledges / returns data.
module tb_regfile_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
`ifdef X0_ZERO_EN
  localparam bit X0 = 1'b1;
`else
  localparam bit X0 = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr_req, clr_ack;
  logic          wb_req, wb_ack;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          rd_req, rd_ack, rd_valid;
  logic [AW-1:0] rd_rs1, rd_rs2;
  logic [DW-1:0] rd_data1, rd_data2;
  logic          busy;
  logic          rf_enable, rf_rw, rf_reset;
  logic [AW-1:0] rf_rs1, rf_rs2, rf_rd;
  logic [DW-1:0] rf_din;
  logic [DW-1:0] rf_out1, rf_out2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            kind;   // 0 = clear, 1 = writeback, 2 = read
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] data;
    logic          en;
  } grant_t;

  typedef struct {
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } rdexp_t;

  grant_t        grant_q[$];
  rdexp_t        exp_rd_q[$];
  int            valid_cyc_q[$];
  logic [DW-1:0] ref_mem[32];
  logic [DW-1:0] rf_mem[32];

  regfile_access_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .clr_req_i  (clr_req),
    .clr_ack_o  (clr_ack),
    .wb_req_i   (wb_req),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data),
    .wb_ack_o   (wb_ack),
    .rd_req_i   (rd_req),
    .rd_rs1_i   (rd_rs1),
    .rd_rs2_i   (rd_rs2),
    .rd_ack_o   (rd_ack),
    .rd_valid_o (rd_valid),
    .rd_data1_o (rd_data1),
    .rd_data2_o (rd_data2),
    .busy_o     (busy),
    .rf_enable_o(rf_enable),
    .rf_rw_o    (rf_rw),
    .rf_reset_o (rf_reset),
    .rf_rs1_o   (rf_rs1),
    .rf_rs2_o   (rf_rs2),
    .rf_rd_o    (rf_rd),
    .rf_din_o   (rf_din),
    .rf_out1_i  (rf_out1),
    .rf_out2_i  (rf_out2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-ported register file with registered read outputs.
  always @(posedge clk) begin
    if (rf_enable) begin
      if (rf_reset) begin
        for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      end else if (rf_rw) begin
        rf_mem[rf_rd] <= rf_din;
      end else begin
        rf_out1 <= rf_mem[rf_rs1];
        rf_out2 <= rf_mem[rf_rs2];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: every ack must match the next queued grant, every rd_valid the next queued result.
  always @(negedge clk) begin : monitor
    grant_t g;
    rdexp_t e;
    int     k;
    int     n_ack;
    n_ack = int'(clr_ack) + int'(wb_ack) + int'(rd_ack);
    if (n_ack > 1) check("ack_onehot", 32'(n_ack), 32'(1));
    if (n_ack != 0) begin
      k = clr_ack ? 0 : (wb_ack ? 1 : 2);
      if (grant_q.size() == 0) begin
        check("unexpected_grant", 32'(k), 32'hFF);
      end else begin
        g = grant_q.pop_front();
        check("grant_kind", 32'(k), 32'(g.kind));
        check("busy_on_grant", 32'(busy), 32'(1));
        case (g.kind)
          0: begin
            check("clr_rf_reset", 32'(rf_reset), 32'(1));
            check("clr_rf_enable", 32'(rf_enable), 32'(1));
          end
          1: begin
            check("wb_rf_rw", 32'(rf_rw), 32'(1));
            check("wb_rf_enable", 32'(rf_enable), 32'(g.en));
            check("wb_rf_rd", 32'(rf_rd), 32'(g.a1));
            check("wb_rf_din", rf_din, g.data);
          end
          default: begin
            check("rd_rf_enable", 32'(rf_enable), 32'(1));
            check("rd_rf_rw", 32'(rf_rw), 32'(0));
            check("rd_rf_rs1", 32'(rf_rs1), 32'(g.a1));
            check("rd_rf_rs2", 32'(rf_rs2), 32'(g.a2));
          end
        endcase
      end
    end
    if (rd_valid) begin
      valid_cyc_q.push_back(cyc);
      if (exp_rd_q.size() == 0) begin
        check("unexpected_valid", 32'(rd_valid), 32'(0));
      end else begin
        e = exp_rd_q.pop_front();
        check("rd_data1", rd_data1, e.d1);
        check("rd_data2", rd_data2, e.d2);
        check("rsp_rf_enable", 32'(rf_enable), 32'(0));
      end
    end
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] idx);
    return (X0 && idx == '0) ? '0 : ref_mem[idx];
  endfunction

  task automatic push_clr();
    grant_t g;
    g.kind = 0; g.a1 = '0; g.a2 = '0; g.data = '0; g.en = 1'b1;
    grant_q.push_back(g);
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
  endtask

  task automatic push_wb(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    grant_t g;
    g.kind = 1; g.a1 = rd; g.a2 = '0; g.data = data; g.en = !(X0 && rd == '0);
    grant_q.push_back(g);
    if (g.en) ref_mem[rd] = data;
  endtask

  task automatic push_rd(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input bit with_data);
    grant_t g;
    rdexp_t e;
    g.kind = 2; g.a1 = rs1; g.a2 = rs2; g.data = '0; g.en = 1'b1;
    grant_q.push_back(g);
    if (with_data) begin
      e.d1 = ref_rd(rs1);
      e.d2 = ref_rd(rs2);
      exp_rd_q.push_back(e);
    end
  endtask

  task automatic wait_for(input int kind, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((kind == 0 && clr_ack) || (kind == 1 && wb_ack) || (kind == 2 && rd_ack)) begin
        ok = 1'b1;
        break;
      end
    end
    check("ack_timeout", 32'(ok), 32'(1));
  endtask

  task automatic do_clr();
    bit ok;
    push_clr();
    clr_req = 1'b1;
    wait_for(0, ok);
    clr_req = 1'b0;
  endtask

  task automatic do_wb(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    bit ok;
    push_wb(rd, data);
    wb_rd = rd; wb_data = data; wb_req = 1'b1;
    wait_for(1, ok);
    wb_req = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    bit ok;
    push_rd(rs1, rs2, 1'b1);
    rd_rs1 = rs1; rd_rs2 = rs2; rd_req = 1'b1;
    wait_for(2, ok);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy && grant_q.size() == 0 && exp_rd_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 32'(done), 32'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            ok;
    int            n;
    logic [AW-1:0] a, b;
    logic [DW-1:0] d;

    reset_n = 1'b0;
    clr_req = 1'b0; wb_req = 1'b0; rd_req = 1'b0;
    wb_rd = '0; wb_data = '0; rd_rs1 = '0; rd_rs2 = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_acks", 32'({clr_ack, wb_ack, rd_ack, rd_valid}), 32'(0));
    check("rst_ctrl", 32'({rf_enable, rf_rw, rf_reset}), 32'(0));
    check("rst_addr", 32'({rf_rs1, rf_rs2, rf_rd}), 32'(0));
    check("rst_din", rf_din, 32'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // start from a known register file
    do_clr();
    drain();

    // write then read back the same index
    do_wb(5'd3, 32'hDEADBEEF);
    @(negedge clk);
    check("rf_rw_pulse_end", 32'({rf_rw, rf_enable}), 32'(0));
    do_rd(5'd3, 5'd0);
    drain();

    // reset in the middle of a read: no response may follow
    push_rd(5'd1, 5'd2, 1'b0);
    rd_rs1 = 5'd1; rd_rs2 = 5'd2; rd_req = 1'b1;
    wait_for(2, ok);
    #1;
    reset_n = 1'b0;
    rd_req  = 1'b0;
    @(negedge clk);
    check("midrd_busy", 32'(busy), 32'(0));
    check("midrd_rf_enable", 32'(rf_enable), 32'(0));
    check("midrd_rd_valid", 32'(rd_valid), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_busy", 32'(busy), 32'(0));

    // both requesters held from reset: rd wins the first tie, then alternate
    push_rd(5'd7, 5'd3, 1'b1);
    push_wb(5'd7, 32'h11110000);
    push_rd(5'd7, 5'd3, 1'b1);
    push_wb(5'd7, 32'h11110000);
    wb_rd = 5'd7; wb_data = 32'h11110000; rd_rs1 = 5'd7; rd_rs2 = 5'd3;
    wb_req = 1'b1; rd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wb_ack || rd_ack) n++;
      if (n == 4) break;
    end
    wb_req = 1'b0; rd_req = 1'b0;
    check("rr_grant_count", 32'(n), 32'(4));
    drain();

    // clear beats both; last grant was wb so rd goes next, read sees zeros
    push_clr();
    push_rd(5'd9, 5'd3, 1'b1);
    push_wb(5'd9, 32'hA5A5A5A5);
    wb_rd = 5'd9; wb_data = 32'hA5A5A5A5; rd_rs1 = 5'd9; rd_rs2 = 5'd3;
    clr_req = 1'b1; wb_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (clr_ack) clr_req = 1'b0;
      if (wb_ack)  wb_req  = 1'b0;
      if (rd_ack)  rd_req  = 1'b0;
      if (!clr_req && !wb_req && !rd_req) break;
    end
    check("multi_done", 32'({clr_req, wb_req, rd_req}), 32'(0));
    drain();

    // index 0 behaviour (hard-wired zero only with X0_ZERO_EN)
    do_wb(5'd0, 32'd5);
    do_rd(5'd0, 5'd0);
    drain();

    // mixed serial traffic
    for (int i = 0; i < 12; i++) begin
      a = 5'($urandom_range(31, 0));
      b = 5'($urandom_range(31, 0));
      d = $urandom;
      if ($urandom_range(1, 0) == 1) do_wb(a, d);
      else                           do_rd(a, b);
    end
    drain();

    // read request held past its ack is granted again three cycles later
    do_wb(5'd3, 32'hCAFEF00D);
    drain();
    valid_cyc_q.delete();
    push_rd(5'd3, 5'd9, 1'b1);
    push_rd(5'd3, 5'd9, 1'b1);
    rd_rs1 = 5'd3; rd_rs2 = 5'd9; rd_req = 1'b1;
    wait_for(2, ok);
    repeat (3) @(negedge clk);
    check("rd_regrant", 32'(rd_ack), 32'(1));
    rd_req = 1'b0;
    drain();
    check("valid_count", 32'(valid_cyc_q.size()), 32'(2));
    if (valid_cyc_q.size() == 2)
      check("valid_gap", 32'(valid_cyc_q[1] - valid_cyc_q[0]), 32'(3));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
